// File: rtl/apb4_master_pkg.sv
// apb4_master_pkg
//   Shared types and default widths for the APB4 command master.
//   - fsm_state_t : transfer sequencer states
//   - cmd_t/rsp_t : command and response records at the default widths
//   - cmd_bits()  : flattened command width for a given address/data width
package apb4_master_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 3;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int unsigned APB_PROT_WIDTH = 3;
  localparam int unsigned CMD_FIFO_DEPTH = 4;
  localparam int unsigned ACCESS_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } fsm_state_t;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] strb;
    logic [APB_PROT_WIDTH-1:0] prot;
  } cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      tmo;
  } rsp_t;

  function automatic int unsigned cmd_bits(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + dw / 8 + APB_PROT_WIDTH;
  endfunction

endpackage

// File: rtl/apb4_cmd_fifo.sv
// apb4_cmd_fifo
//   Synchronous FIFO holding flattened commands; synchronous active-high reset.
//   Ports: clk, rst, push/push_data (write side), pop/pop_data (head, read side),
//          full, empty, level (entries stored).
//   Pushes while full and pops while empty are ignored.
module apb4_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
  end

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (PTR_WIDTH + 1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[PTR_WIDTH-1:0]];

endmodule

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master
//   APB4 requester: buffers valid/ready commands in a FIFO, runs each as one
//   SETUP/ACCESS transfer honouring PREADY wait states, and returns one
//   response per command in order (one transfer outstanding at a time).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     i_cmd_* / o_cmd_ready         command stream (write, addr, wdata, strb, prot)
//     o_rsp_* / i_rsp_ready         response stream (rdata, err, tmo)
//     o_p* / i_p*                   APB4 requester interface
//     o_fifo_level                  commands currently buffered
//   Optional feature macro: APB4_CMD_TIMEOUT_EN -- aborts an ACCESS phase that
//   has lasted TIMEOUT_CYCLES cycles without PREADY (err=1, tmo=1, rdata=0).
module apb4_cmd_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = CMD_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = ACCESS_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]         i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]         i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]       i_cmd_strb,
  input  logic [2:0]                    i_cmd_prot,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic                          o_rsp_tmo,
  output logic                          o_psel,
  output logic                          o_penable,
  output logic                          o_pwrite,
  output logic [ADDR_WIDTH-1:0]         o_paddr,
  output logic [DATA_WIDTH-1:0]         o_pwdata,
  output logic [DATA_WIDTH/8-1:0]       o_pstrb,
  output logic [2:0]                    o_pprot,
  input  logic                          i_pready,
  input  logic [DATA_WIDTH-1:0]         i_prdata,
  input  logic                          i_pslverr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CMD_WIDTH  = cmd_bits(ADDR_WIDTH, DATA_WIDTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fsm_state_t state;
  fsm_state_t state_nxt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CMD_WIDTH-1:0]  fifo_in;
  logic [CMD_WIDTH-1:0]  fifo_out;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_WIDTH-1:0] head_strb;
  logic [2:0]            head_prot;

  // Ready is forced low during reset so nothing is accepted into a FIFO being cleared.
  assign o_cmd_ready = !rst && !fifo_full;
  assign push        = i_cmd_valid && o_cmd_ready;
  assign fifo_in     = {i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_strb, i_cmd_prot};
  assign {head_write, head_addr, head_wdata, head_strb, head_prot} = fifo_out;

  apb4_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_fifo_level)
  );

`ifdef APB4_CMD_TIMEOUT_EN
  localparam int unsigned TMO_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_CNT_WIDTH-1:0] tmo_cnt;
  logic                     tmo_hit;

  // Counts completed ACCESS cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  // PREADY on the limit cycle takes priority, so the abort needs it low.
  assign tmo_hit = (state == ACCESS) && !i_pready &&
                   (tmo_cnt == TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
`ifdef APB4_CMD_TIMEOUT_EN
        if (i_pready || tmo_hit) state_nxt = RESP;
`else
        if (i_pready) state_nxt = RESP;
`endif
      end
      RESP: begin
        if (i_rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_psel      = (state == SETUP) || (state == ACCESS);
  assign o_penable   = (state == ACCESS);
  assign o_rsp_valid = (state == RESP);

  // Payload is latched on the pop that starts SETUP and held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pwrite <= 1'b0;
      o_paddr  <= '0;
      o_pwdata <= '0;
      o_pstrb  <= '0;
      o_pprot  <= '0;
    end else if (pop) begin
      o_pwrite <= head_write;
      o_paddr  <= head_addr;
      o_pwdata <= head_write ? head_wdata : '0;
      o_pstrb  <= head_write ? head_strb : '0;
      o_pprot  <= head_prot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      if (i_pready) begin
        o_rsp_rdata <= (o_pwrite || i_pslverr) ? '0 : i_prdata;
        o_rsp_err   <= i_pslverr;
      end
`ifdef APB4_CMD_TIMEOUT_EN
      else if (tmo_hit) begin
        o_rsp_rdata <= '0;
        o_rsp_err   <= 1'b1;
      end
`endif
    end
  end

`ifdef APB4_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                                o_rsp_tmo <= 1'b0;
    else if (state == ACCESS && i_pready)   o_rsp_tmo <= 1'b0;
    else if (tmo_hit)                       o_rsp_tmo <= 1'b1;
  end
`else
  assign o_rsp_tmo = 1'b0;
`endif

endmodule
